uart_rx: RTL and testbench

UART receive path: oversamples the asynchronous `rx_serial` line with a configurable clocks-per-bit count and recovers 8N1 frames (optionally 8E1). Each good byte is presented with a one-cycle `rx_dv` strobe. The block is the receive counterpart of the transmit FSM/datapath and sits between the board pin and the LFSR command/data logic. It is a self-contained receiver: control FSM plus shift/count datapath.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_fsm.sv | 91 +++++++++
 rtl/uart_rx.sv | 97 +++++++++
 tb/tb_uart_rx.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and frame constants
package uart_pkg;

  localparam int UART_DATA_BITS            = 8;
  localparam int UART_DEFAULT_CLKS_PER_BIT = 87;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    CLEANUP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_fsm.sv
// rtl/uart_rx_fsm.sv - UART receive control FSM driving the uart_rx datapath
// UART_RX_PARITY_EN inserts the PARITY state between DATA and STOP.
module uart_rx_fsm
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic rxs,
  input  logic rxs_d,
  input  logic half_bit,
  input  logic full_bit,
  input  logic last_bit,
  input  logic par_fail,
  output logic cnt_clr,
  output logic bit_clr,
  output logic bit_inc,
  output logic shift_en,
`ifdef UART_RX_PARITY_EN
  output logic par_en,
`endif
  output logic load_byte,
  output logic rx_active,
  output logic rx_dv,
  output logic framing_err,
  output logic parity_err
);

  rx_state_t state;

  // Counter restarts on every state change and after every in-state sample.
  assign cnt_clr   = (state == IDLE) || (state == CLEANUP) ||
                     ((state == START) && half_bit) ||
                     ((state inside {DATA, PARITY, STOP}) && full_bit);
  assign bit_clr   = (state == START) && half_bit && !rxs;
  assign shift_en  = (state == DATA) && full_bit;
  assign bit_inc   = shift_en && !last_bit;
`ifdef UART_RX_PARITY_EN
  assign par_en    = (state == PARITY) && full_bit;
`endif
  assign load_byte = (state == STOP) && full_bit && rxs && !par_fail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rx_active   <= 1'b0;
      rx_dv       <= 1'b0;
      framing_err <= 1'b0;
      parity_err  <= 1'b0;
    end else begin
      rx_dv       <= 1'b0;
      framing_err <= 1'b0;
      parity_err  <= 1'b0;
      case (state)
        IDLE: begin
          rx_active <= 1'b0;
          if (rxs_d && !rxs) state <= START;
        end
        START: begin
          if (half_bit) begin
            if (!rxs) begin
              rx_active <= 1'b1;
              state     <= DATA;
            end else begin
              state <= IDLE;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        DATA:   if (full_bit && last_bit) state <= PARITY;
        PARITY: if (full_bit) state <= STOP;
`else
        DATA:   if (full_bit && last_bit) state <= STOP;
`endif
        STOP: begin
          if (full_bit) begin
            rx_dv       <= rxs && !par_fail;
            framing_err <= !rxs;
            parity_err  <= par_fail;
            state       <= CLEANUP;
          end
        end
        CLEANUP: begin
          rx_active <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver top: synchronizer, bit counter, shift register, outputs
// UART_RX_PARITY_EN selects 8E1 framing; default build is 8N1 with parity_err tied low.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_serial,
  output logic       rx_dv,
  output logic [7:0] rx_byte,
  output logic       rx_active,
  output logic       framing_err,
  output logic       parity_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int H  = (CLKS_PER_BIT - 1) / 2;

  logic                      rx_meta, rxs, rxs_d;
  logic [CW-1:0]             clk_cnt;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic half_bit, full_bit, last_bit, par_fail;
  logic cnt_clr, bit_clr, bit_inc, shift_en, load_byte;

  // Synchronizer flops reset high so releasing reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
    end else begin
      rx_meta <= rx_serial;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
    end
  end

  assign half_bit = (clk_cnt == CW'(H));
  assign full_bit = (clk_cnt == CW'(CLKS_PER_BIT - 1));
  assign last_bit = (bit_idx == 3'(UART_DATA_BITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      rx_byte <= '0;
    end else begin
      clk_cnt <= cnt_clr ? '0 : clk_cnt + 1'b1;
      if (bit_clr)      bit_idx <= '0;
      else if (bit_inc) bit_idx <= bit_idx + 3'd1;
      if (shift_en)  shreg[bit_idx] <= rxs;
      if (load_byte) rx_byte <= shreg;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_en, par_q;

  // Even parity: the received parity bit must equal the XOR of the data bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       par_q <= 1'b0;
    else if (bit_clr) par_q <= 1'b0;
    else if (par_en)  par_q <= rxs ^ (^shreg);
  end
  assign par_fail = par_q;
`else
  assign par_fail = 1'b0;
`endif

  uart_rx_fsm u_fsm (
    .clk         (clk),
    .rst_n       (rst_n),
    .rxs         (rxs),
    .rxs_d       (rxs_d),
    .half_bit    (half_bit),
    .full_bit    (full_bit),
    .last_bit    (last_bit),
    .par_fail    (par_fail),
    .cnt_clr     (cnt_clr),
    .bit_clr     (bit_clr),
    .bit_inc     (bit_inc),
    .shift_en    (shift_en),
`ifdef UART_RX_PARITY_EN
    .par_en      (par_en),
`endif
    .load_byte   (load_byte),
    .rx_active   (rx_active),
    .rx_dv       (rx_dv),
    .framing_err (framing_err),
    .parity_err  (parity_err)
  );

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx (CLKS_PER_BIT=8), honours UART_RX_PARITY_EN
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CPB = 8;
  localparam int H   = (CPB - 1) / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NB  = 10;
`else
  localparam int NB  = 9;
`endif
  // Pin edge to start sample: 2 sync flops, 1 cycle edge detect, H+1 cycles in START.
  localparam int LAT = 4 + H;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_serial = 1'b1;
  logic       rx_dv, rx_active, framing_err, parity_err;
  logic [7:0] rx_byte;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_serial   (rx_serial),
    .rx_dv       (rx_dv),
    .rx_byte     (rx_byte),
    .rx_active   (rx_active),
    .framing_err (framing_err),
    .parity_err  (parity_err)
  );

  typedef struct {
    int         cyc;
    bit         dv;
    bit         fe;
    bit         pe;
    logic [7:0] b;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    bit         stop;
    bit         flip;
    int         gap;
    bit         dv;
    bit         fe;
    bit         pe;
    logic [7:0] b;
  } vec_t;

  ev_t        exp_q[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         n_strobes = 0;
  int         active_cycles = 0;
  bit         prev_strobe = 1'b0;
  logic [7:0] last_good = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Strobe monitor: every strobe cycle must match the next predicted event.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_active) active_cycles++;
      if (prev_strobe) check("rx_active_drop", {31'd0, rx_active}, 32'd0);
      prev_strobe = 1'b0;
      if (rx_dv || framing_err || parity_err) begin
        ev_t e;
        n_strobes++;
        prev_strobe = 1'b1;
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", {29'd0, rx_dv, framing_err, parity_err}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("strobe_cycle", cyc, e.cyc);
          check("rx_dv", {31'd0, rx_dv}, {31'd0, e.dv});
          check("framing_err", {31'd0, framing_err}, {31'd0, e.fe});
          check("parity_err", {31'd0, parity_err}, {31'd0, e.pe});
          check("rx_byte", {24'd0, rx_byte}, {24'd0, e.b});
          check("rx_active_at_strobe", {31'd0, rx_active}, 32'd1);
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    rx_serial = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop, input bit flip, input int gap);
    logic p;
    p = (^d) ^ flip;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(p);
`else
    if (p === 1'bx) $display("parity bit undefined");
`endif
    send_bit(stop);
    rx_serial = 1'b1;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  // Reference model: outcome of a frame from its stop bit and parity bit alone.
  task automatic predict(input logic [7:0] d, input bit stop, input bit flip);
    ev_t e;
`ifdef UART_RX_PARITY_EN
    e.pe = flip;
`else
    e.pe = 1'b0;
    if (flip) e.pe = 1'b0;
`endif
    e.fe  = !stop;
    e.dv  = stop && !e.pe;
    if (e.dv) last_good = d;
    e.b   = last_good;
    e.cyc = cyc + LAT + NB * CPB;
    exp_q.push_back(e);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rx_dv"}, {31'd0, rx_dv}, 32'd0);
    check({tag, "_rx_byte"}, {24'd0, rx_byte}, 32'd0);
    check({tag, "_rx_active"}, {31'd0, rx_active}, 32'd0);
    check({tag, "_framing_err"}, {31'd0, framing_err}, 32'd0);
    check({tag, "_parity_err"}, {31'd0, parity_err}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    int   a0, s0;
    ev_t  e;

    vecs.push_back('{8'hA5, 1'b1, 1'b0, 12, 1'b1, 1'b0, 1'b0, 8'hA5});
    vecs.push_back('{8'h3C, 1'b1, 1'b0, 5,  1'b1, 1'b0, 1'b0, 8'h3C});
    vecs.push_back('{8'h3C, 1'b0, 1'b0, 10, 1'b0, 1'b1, 1'b0, 8'h3C});
    vecs.push_back('{8'h00, 1'b1, 1'b0, 0,  1'b1, 1'b0, 1'b0, 8'h00});
    vecs.push_back('{8'hFF, 1'b1, 1'b0, 4,  1'b1, 1'b0, 1'b0, 8'hFF});
`ifdef UART_RX_PARITY_EN
    vecs.push_back('{8'h81, 1'b1, 1'b1, 6,  1'b0, 1'b0, 1'b1, 8'hFF});
    vecs.push_back('{8'h81, 1'b1, 1'b0, 6,  1'b1, 1'b0, 1'b0, 8'h81});
`endif

    rst_n = 1'b0;
    rx_serial = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      e.cyc = cyc + LAT + NB * CPB;
      e.dv  = vecs[i].dv;
      e.fe  = vecs[i].fe;
      e.pe  = vecs[i].pe;
      e.b   = vecs[i].b;
      exp_q.push_back(e);
      last_good = vecs[i].b;
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].flip, vecs[i].gap);
    end

    // Two-cycle glitch is rejected at the start sample.
    a0 = active_cycles;
    s0 = n_strobes;
    rx_serial = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rx_serial = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("glitch_rx_active", active_cycles - a0, 0);
    check("glitch_strobes", n_strobes - s0, 0);

    // Break: one all-zero frame with a framing error, then no re-arm while low.
    predict(8'h00, 1'b0, 1'b0);
    rx_serial = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    rx_serial = 1'b1;
    repeat (20) @(posedge clk);
    #1;

    // Reset in the middle of data bit 4 of 0x12.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i == 1);
    rx_serial = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_outputs_zero("midreset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    last_good = 8'h00;
    repeat (20) @(posedge clk);
    #1;
    predict(8'h5A, 1'b1, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0, 10);

    // Randomized frames against the model.
    for (int i = 0; i < 25; i++) begin
      logic [7:0] d;
      bit stop, flip;
      int gap;
      d    = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
`ifdef UART_RX_PARITY_EN
      flip = ($urandom_range(0, 3) == 0);
`else
      flip = 1'b0;
`endif
      gap  = stop ? $urandom_range(0, 20) : CPB + $urandom_range(0, 10);
      predict(d, stop, flip);
      send_frame(d, stop, flip, gap);
    end

    repeat (40) @(posedge clk);
    #1;
    check("pending_events", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
